// File: rtl/av_regs_pkg.sv
// Shared definitions for the Avalon-MM status register file:
// transmit FSM state encoding, CTRL/STATUS word addresses, bit positions
// and a helper that packs the STATUS word.
package av_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_t;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_STATUS  = 1;
    localparam int PAYLOAD_BASE = 2;

    localparam int CTRL_SEND_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_CNT_LSB     = 8;

    // Lower 16 bits of the STATUS word; everything above reads 0.
    function automatic logic [15:0] pack_status(input logic       busy,
                                                input logic       done,
                                                input logic       overrun,
                                                input logic [7:0] send_cnt);
        logic [15:0] v;
        v = '0;
        v[STAT_BUSY_BIT]                 = busy;
        v[STAT_DONE_BIT]                 = done;
        v[STAT_OVERRUN_BIT]              = overrun;
        v[STAT_CNT_LSB +: 8]             = send_cnt;
        return v;
    endfunction

endpackage

// File: rtl/udp_send_ctrl.sv
// Transmit sequencer: issues a one-cycle udp_send, waits for udp_done,
// keeps the completed-transaction counter and the sticky DONE/OVERRUN flags.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - CTRL write with SEND=1 this cycle
//   payload_wr_busy     - payload write attempted this cycle (blocked if busy)
//   clr_done, clr_ovr   - write-1-to-clear strobes from STATUS writes
//   udp_done            - completion pulse from the UDP module
//   udp_send            - one-cycle transmit request (registered)
//   busy, done, overrun - status flags
//   send_cnt            - completed transactions modulo 256
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for a SEND write
// SEND  | udp_send asserted for exactly this cycle
// WAIT  | waiting for udp_done; payload frozen
module udp_send_ctrl
    import av_regs_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       payload_wr_busy,
    input  logic       clr_done,
    input  logic       clr_ovr,
    input  logic       udp_done,
    output logic       udp_send,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] send_cnt
);

    tx_state_t  r_state;
    logic       r_udp_send;
    logic       r_done;
    logic       r_overrun;
    logic [7:0] r_send_cnt;

    logic       w_busy;
    logic       w_done_set;
    logic       w_ovr_set;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_done_set = (r_state == ST_WAIT) && udp_done;
    assign w_ovr_set  = (start && w_busy) || payload_wr_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_udp_send <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_send_cnt <= 8'd0;
        end else begin
            r_udp_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SEND;
                        r_udp_send <= 1'b1;
                    end
                end
                ST_SEND: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (udp_done) begin
                        r_state    <= ST_IDLE;
                        r_send_cnt <= r_send_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Set wins over a same-cycle write-1-to-clear.
            if (w_done_set)
                r_done <= 1'b1;
            else if (clr_done)
                r_done <= 1'b0;

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (clr_ovr)
                r_overrun <= 1'b0;
        end
    end

    assign udp_send = r_udp_send;
    assign busy     = w_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign send_cnt = r_send_cnt;

endmodule

// File: rtl/av_status_regfile.sv
// Avalon-MM register file: CTRL, STATUS and NUM_REGS payload words that are
// presented in parallel on regs_o and handed to a UDP transmitter.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   address, write, read       - Avalon-MM word address and strobes
//   writedata, byteenable      - write data and per-byte enables
//   readdata, readdatavalid    - registered read response (latency 1)
//   regs_o                     - payload k at [k*DATA_W +: DATA_W]
//   udp_send, udp_done         - transmit request / completion handshake
//   irq                        - DONE and IRQ_EN
// STATUS packs SEND_CNT into bits [15:8], so DATA_W must be at least 16.
module av_status_regfile
    import av_regs_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       write,
    input  logic                       read,
    input  logic [DATA_W-1:0]          writedata,
    input  logic [DATA_W/8-1:0]        byteenable,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       udp_send,
    input  logic                       udp_done,
    output logic                       irq
);

    logic [DATA_W-1:0] r_payload [NUM_REGS];
    logic              r_irq_en;
    logic [DATA_W-1:0] r_readdata;
    logic              r_readdatavalid;

    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_start;
    logic              w_pay_hit;
    logic              w_pay_blocked;
    logic              w_busy;
    logic              w_done;
    logic              w_overrun;
    logic [7:0]        w_send_cnt;
    logic [DATA_W-1:0] w_rdata;

    // CTRL/STATUS only honour the low byte lane.
    assign w_wr_ctrl   = write && byteenable[0] && (address == ADDR_W'(ADDR_CTRL));
    assign w_wr_status = write && byteenable[0] && (address == ADDR_W'(ADDR_STATUS));
    assign w_start     = w_wr_ctrl && writedata[CTRL_SEND_BIT];

    // One extra bit so the upper bound cannot wrap when the map fills the space.
    assign w_pay_hit = ({1'b0, address} >= (ADDR_W+1)'(PAYLOAD_BASE)) &&
                       ({1'b0, address} <  (ADDR_W+1)'(PAYLOAD_BASE + NUM_REGS));
    assign w_pay_blocked = write && w_pay_hit && w_busy;

    udp_send_ctrl u_ctrl (
        .clk             (clk),
        .reset           (reset),
        .start           (w_start),
        .payload_wr_busy (w_pay_blocked),
        .clr_done        (w_wr_status && writedata[STAT_DONE_BIT]),
        .clr_ovr         (w_wr_status && writedata[STAT_OVERRUN_BIT]),
        .udp_done        (udp_done),
        .udp_send        (udp_send),
        .busy            (w_busy),
        .done            (w_done),
        .overrun         (w_overrun),
        .send_cnt        (w_send_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++)
                r_payload[k] <= '0;
        end else begin
            if (w_wr_ctrl)
                r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
            // Payload is frozen while a transaction is in flight.
            if (write && !w_busy) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (address == ADDR_W'(PAYLOAD_BASE + k)) begin
                        for (int b = 0; b < DATA_W/8; b++) begin
                            if (byteenable[b])
                                r_payload[k][b*8 +: 8] <= writedata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux sees pre-write register values, giving old data on a
    // same-cycle read/write of one address.
    always_comb begin
        w_rdata = '0;
        if (address == ADDR_W'(ADDR_CTRL))
            w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
        else if (address == ADDR_W'(ADDR_STATUS))
            w_rdata[15:0] = pack_status(w_busy, w_done, w_overrun, w_send_cnt);
        for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDR_W'(PAYLOAD_BASE + k))
                w_rdata = r_payload[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (read)
                r_readdata <= w_rdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = r_payload[g];
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign irq           = w_done && r_irq_en;

endmodule

// File: tb/tb_av_status_regfile.sv
module tb_av_status_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [255:0] regs_o;
    logic        udp_send;
    logic        udp_done;
    logic        irq;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_send = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    av_status_regfile #(.NUM_REGS(8), .DATA_W(32), .ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .write         (write),
        .read          (read),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .regs_o        (regs_o),
        .udp_send      (udp_send),
        .udp_done      (udp_done),
        .irq           (irq)
    );

    // Scoreboard monitor: every readdatavalid pops one expected word.
    always @(negedge clk) begin
        if (udp_send) n_send++;
        if (readdatavalid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: readdatavalid with data %h, none expected", readdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (readdata !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got %h expected %h", readdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic dn, input logic [31:0] exp);
        address    = a;
        write      = w;
        read       = r;
        writedata  = d;
        byteenable = be;
        udp_done   = dn;
        if (r) exp_q.push_back(exp);
        @(posedge clk); #1;
        write    = 1'b0;
        read     = 1'b0;
        udp_done = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b1, 1'b0, a, d, be, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        cyc(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic done_pulse();
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    endtask

    initial begin
        int ns;
        reset = 1'b1; address = '0; write = 0; read = 0;
        writedata = '0; byteenable = '0; udp_done = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_udp_send", udp_send, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rdv", readdatavalid, 0);
        chk("rst_readdata", readdata, 0);
        rd(4'd1, 32'h0);
        rd(4'd0, 32'h0);
        rd(4'd2, 32'h0);

        // Byte-enabled payload writes
        wr(4'd2, 32'hDEADBEEF, 4'b0011);
        rd(4'd2, 32'h0000BEEF);
        wr(4'd3, 32'h12345678, 4'b1111);
        wr(4'd3, 32'hAABBCCDD, 4'b1010);
        rd(4'd3, 32'hAA34CC78);
        chk("regs_o_p1", regs_o[63:32], 32'hAA34CC78);
        wr(4'd9, 32'hCAFEF00D, 4'b1111);
        rd(4'd9, 32'hCAFEF00D);
        chk("regs_o_p7", regs_o[255:224], 32'hCAFEF00D);

        // Same-cycle read/write returns old value
        cyc(1'b1, 1'b1, 4'd3, 32'h0, 4'hF, 1'b0, 32'hAA34CC78);
        rd(4'd3, 32'h0);

        // Unmapped
        rd(4'd15, 32'h0);
        wr(4'd10, 32'hFFFFFFFF, 4'hF);
        rd(4'd10, 32'h0);
        wr(4'd15, 32'hFFFFFFFF, 4'hF);
        rd(4'd15, 32'h0);

        // Basic transaction
        wr(4'd0, 32'h1, 4'h1);
        chk("send_hi", udp_send, 1);
        idle(1);
        chk("send_lo", udp_send, 0);
        chk("send_count1", n_send, 1);
        rd(4'd1, 32'h0000_0001);
        idle(3);
        done_pulse();
        rd(4'd1, 32'h0000_0102);
        chk("irq_dis", irq, 0);
        rd(4'd0, 32'h0);

        // Set beats same-cycle clear
        wr(4'd1, 32'h2, 4'h1);
        rd(4'd1, 32'h0000_0100);
        wr(4'd0, 32'h1, 4'h1);
        idle(1);
        cyc(1'b1, 1'b0, 4'd1, 32'h2, 4'h1, 1'b1, 32'h0);
        rd(4'd1, 32'h0000_0202);
        wr(4'd1, 32'h2, 4'h1);

        // Overrun while WAIT
        wr(4'd0, 32'h1, 4'h1);
        idle(1);
        ns = n_send;
        wr(4'd0, 32'h1, 4'h1);
        wr(4'd2, 32'hFFFFFFFF, 4'hF);
        idle(1);
        chk("no_2nd_send", n_send, ns);
        rd(4'd2, 32'h0000BEEF);
        rd(4'd1, 32'h0000_0205);
        wr(4'd1, 32'h4, 4'h0);
        rd(4'd1, 32'h0000_0205);
        wr(4'd1, 32'h4, 4'h1);
        rd(4'd1, 32'h0000_0201);
        done_pulse();
        rd(4'd1, 32'h0000_0302);

        // udp_done ignored in IDLE and SEND
        done_pulse();
        rd(4'd1, 32'h0000_0302);
        wr(4'd1, 32'h2, 4'h1);
        wr(4'd0, 32'h1, 4'h1);
        done_pulse();
        rd(4'd1, 32'h0000_0301);
        done_pulse();
        rd(4'd1, 32'h0000_0402);
        wr(4'd2, 32'h11223344, 4'b1100);
        rd(4'd2, 32'h1122BEEF);

        // Reset mid-transaction
        wr(4'd0, 32'h2, 4'h1);
        wr(4'd0, 32'h3, 4'h1);
        idle(1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_send", udp_send, 0);
        done_pulse();
        chk("rst_mid_irq", irq, 0);
        rd(4'd1, 32'h0);
        rd(4'd0, 32'h0);
        rd(4'd2, 32'h0);

        // 256 transactions with IRQ_EN, counter wraps to 0
        wr(4'd0, 32'h2, 4'h1);
        for (int i = 0; i < 256; i++) begin
            wr(4'd0, 32'h3, 4'h1);
            idle(1);
            done_pulse();
            chk("irq_set", irq, 1);
            wr(4'd1, 32'h2, 4'h1);
            chk("irq_clr", irq, 0);
        end
        rd(4'd1, 32'h0);
        rd(4'd0, 32'h2);

        idle(3);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/av_status_regfile.md
AV_STATUS_REGFILE -- requirements
Module: av_status_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning payload register count (1..14).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register and bus width (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 4, meaning word address width; NUM_REGS+2 <= 2**ADDR_W.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, as listed in REQ-005 and REQ-006.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning the synchronous active-high reset.
REQ-007 SHALL have port address, input, ADDR_W, meaning the Avalon-MM word address.
REQ-008 SHALL have ports write and read, input, 1 each, meaning the Avalon-MM strobes.
REQ-009 SHALL have port writedata, input, DATA_W, meaning the write data.
REQ-010 SHALL have port byteenable, input, DATA_W/8, meaning per-byte write enables.
REQ-011 SHALL have port readdata, output, DATA_W, meaning the registered read data.
REQ-012 SHALL have port readdatavalid, output, 1, meaning readdata is valid this cycle.
REQ-013 SHALL have port regs_o, output, NUM_REGS*DATA_W, meaning the payload registers; payload k occupies bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port udp_send, output, 1, meaning a one-cycle transmit request to the UDP module.
REQ-015 SHALL have port udp_done, input, 1, meaning a one-cycle transmit completion from the UDP module.
REQ-016 SHALL have port irq, output, 1, meaning the completion interrupt (level).

Function
REQ-017 SHALL map the registers as follows: address 0 CTRL, 1 STATUS, 2..NUM_REGS+1 payload 0..NUM_REGS-1; all other addresses are unmapped.
REQ-018 SHALL define CTRL as: bit0 SEND (write 1 starts a transaction, reads 0), bit1 IRQ_EN (read/write), all other bits reading 0.
REQ-019 SHALL define STATUS as: bit0 BUSY (read-only), bit1 DONE (sticky, write-1-to-clear), bit2 OVERRUN (sticky, write-1-to-clear), bits[15:8] SEND_CNT (read-only), all other bits reading 0.
REQ-020 SHALL write payload bytes only where byteenable is 1; CTRL and STATUS writes SHALL use writedata[7:0] only when byteenable[0]=1.
REQ-021 SHALL ignore writes to unmapped addresses.
REQ-022 SHALL register reads with latency 1: a read at cycle N yields readdata and readdatavalid=1 at cycle N+1, and readdatavalid=0 otherwise.
REQ-023 SHALL return 0 for unmapped reads, and SHALL hold readdata at its last value when readdatavalid=0.
REQ-024 SHALL return the pre-write value when read and write target the same address in the same cycle.
REQ-025 SHALL implement a transmit FSM with states IDLE, SEND and WAIT.
REQ-026 SHALL move IDLE->SEND on a CTRL write with bit0=1; SEND SHALL last exactly one cycle with udp_send=1, then go to WAIT.
REQ-027 SHALL move WAIT->IDLE on udp_done=1, setting DONE and incrementing SEND_CNT modulo 256 (255 wraps to 0).
REQ-028 SHALL hold BUSY=1 in SEND and WAIT, and SHALL hold udp_send=0 in every state except SEND.
REQ-029 SHALL ignore a SEND write while BUSY=1 (no second transaction) and SHALL set OVERRUN.
REQ-030 SHALL ignore payload writes while BUSY=1 and SHALL set OVERRUN, so regs_o is stable for the whole transaction.
REQ-031 SHALL ignore udp_done in IDLE and SEND.
REQ-032 SHALL let a set take priority over a same-cycle write-1-to-clear for DONE and for OVERRUN.
REQ-033 SHALL drive irq = DONE AND IRQ_EN.

Reset
REQ-034 SHALL, when reset=1 at a clock edge, return the FSM to IDLE and clear all registers, SEND_CNT, readdata, readdatavalid, udp_send and irq to 0, including mid-transaction; a udp_done arriving after reset SHALL be ignored.

Structure
REQ-035 SHALL place the FSM state enum, the CTRL/STATUS addresses and the bit-position constants in the shared package av_regs_pkg.
REQ-036 SHALL implement the FSM, SEND_CNT and the sticky flags as the sub-module udp_send_ctrl; the register file and read mux SHALL remain in the top level.

Verification
REQ-037 SHALL cover: write 0xDEADBEEF to address 2 with byteenable=4'b0011 over reset-zero contents -> read address 2 returns 0x0000BEEF one cycle later with readdatavalid=1.
REQ-038 SHALL cover: CTRL write 0x1 -> udp_send high exactly 1 cycle, next cycle; BUSY=1; udp_done 5 cycles later -> BUSY=0, DONE=1, SEND_CNT=1.
REQ-039 SHALL cover: CTRL write 0x1 while in WAIT, plus a payload write -> no udp_send, payload unchanged, OVERRUN=1; writing STATUS 0x4 clears OVERRUN.
REQ-040 SHALL cover: 256 complete transactions -> SEND_CNT reads 0; with IRQ_EN=1, irq=1 after each, and STATUS write 0x2 drops irq.
REQ-041 SHALL cover: reset asserted in WAIT, then udp_done pulsed -> FSM in IDLE, DONE=0, SEND_CNT=0, irq=0.
REQ-042 SHALL cover: read of address 15 (NUM_REGS=8) -> readdata 0, readdatavalid=1; same-cycle read/write of address 3 -> old value returned.
